// File: rtl/wspr_symbol_sequencer_if.sv
// Bundle for the sequencer: symbol write port, playback controls and the
// symbol/tone stream handed to the NCO stage.
interface wspr_symbol_sequencer_if #(
   parameter int SYMBOL_BITS = 2,
   parameter int DEPTH       = 162,
   parameter int FTW_WIDTH   = 32
);
   localparam int IW = $clog2(DEPTH);

   logic                   wr_valid;
   logic [SYMBOL_BITS-1:0] wr_data;
   logic                   wr_ready;
   logic                   flush;
   logic                   start;
   logic                   abort;
   logic                   repeat_en;
   logic                   loaded;
   logic                   busy;
   logic                   symbol_valid;
   logic                   symbol_strobe;
   logic [IW-1:0]          index;
   logic [SYMBOL_BITS-1:0] symbol;
   logic [FTW_WIDTH-1:0]   tone_offset;
   logic                   done;

   modport master (
      output wr_valid, wr_data, flush, start, abort, repeat_en,
      input  wr_ready, loaded, busy, symbol_valid, symbol_strobe,
             index, symbol, tone_offset, done
   );

   modport slave (
      input  wr_valid, wr_data, flush, start, abort, repeat_en,
      output wr_ready, loaded, busy, symbol_valid, symbol_strobe,
             index, symbol, tone_offset, done
   );
endinterface

// File: rtl/wspr_symbol_sequencer.sv
// M-FSK symbol sequencer: buffers DEPTH symbols, then plays each for
// SYMBOL_PERIOD cycles with optional repeat and abort.
module wspr_symbol_sequencer #(
   parameter int SYMBOL_BITS   = 2,
   parameter int DEPTH         = 162,
   parameter int SYMBOL_PERIOD = 34133333,
   parameter int FTW_WIDTH     = 32,
   parameter int TONE_STEP     = 117
) (
   input logic                    clk,
   input logic                    reset,
   wspr_symbol_sequencer_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(SYMBOL_PERIOD);
   localparam logic [FTW_WIDTH-1:0] STEP = FTW_WIDTH'(TONE_STEP);

   typedef enum logic [1:0] {LOAD, READY, PLAY} state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          count, count_n;
   logic [IW-1:0]          idx, idx_n;
   logic [PW-1:0]          pcnt, pcnt_n;
   logic                   strobe, strobe_n;
   logic                   done_q, done_n;
   logic [SYMBOL_BITS-1:0] sym_q, sym_n;
   logic [FTW_WIDTH-1:0]   tone_q, tone_n;
   logic                   wr_en;

   logic [SYMBOL_BITS-1:0] mem [DEPTH];

   always_comb begin
      state_n  = state;
      count_n  = count;
      idx_n    = '0;
      pcnt_n   = '0;
      strobe_n = 1'b0;
      done_n   = 1'b0;
      wr_en    = 1'b0;
      case (state)
         LOAD: begin
            if (bus.flush) begin
               count_n = '0;
            end else if (bus.wr_valid) begin
               wr_en   = 1'b1;
               count_n = count + 1'b1;
               if (count == CW'(DEPTH - 1)) state_n = READY;
            end
         end
         READY: begin
            if (bus.flush) begin
               count_n = '0;
               state_n = LOAD;
            end else if (bus.start && !bus.abort) begin
               state_n  = PLAY;
               strobe_n = 1'b1;
            end
         end
         PLAY: begin
            idx_n = idx;
            if (bus.abort) begin
               state_n = READY;
               idx_n   = '0;
            end else if (pcnt == PW'(SYMBOL_PERIOD - 1)) begin
               // Symbol boundary: advance, wrap for repeat, or finish.
               if (idx != IW'(DEPTH - 1)) begin
                  idx_n    = idx + 1'b1;
                  strobe_n = 1'b1;
               end else if (bus.repeat_en) begin
                  idx_n    = '0;
                  strobe_n = 1'b1;
               end else begin
                  idx_n   = '0;
                  state_n = READY;
                  done_n  = 1'b1;
               end
            end else begin
               pcnt_n = pcnt + 1'b1;
            end
         end
         default: state_n = LOAD;
      endcase
      // Output registers hold zero whenever playback is not running.
      sym_n  = (state_n == PLAY) ? mem[idx_n] : '0;
      tone_n = FTW_WIDTH'(sym_n) * STEP;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= LOAD;
         count  <= '0;
         idx    <= '0;
         pcnt   <= '0;
         strobe <= 1'b0;
         done_q <= 1'b0;
         sym_q  <= '0;
         tone_q <= '0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         idx    <= idx_n;
         pcnt   <= pcnt_n;
         strobe <= strobe_n;
         done_q <= done_n;
         sym_q  <= sym_n;
         tone_q <= tone_n;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[IW'(count)] <= bus.wr_data;
   end

   assign bus.wr_ready      = (state == LOAD);
   assign bus.loaded        = (state != LOAD);
   assign bus.busy          = (state == PLAY);
   assign bus.symbol_valid  = (state == PLAY);
   assign bus.symbol_strobe = strobe;
   assign bus.index         = idx;
   assign bus.symbol        = sym_q;
   assign bus.tone_offset   = tone_q;
   assign bus.done          = done_q;
endmodule

// File: tb/tb_wspr_symbol_sequencer.sv
// Directed plus randomized bench for wspr_symbol_sequencer, checked every
// cycle against a message/elapsed-time playback model.
module tb_wspr_symbol_sequencer;
   localparam int SB    = 2;
   localparam int DEPTH = 4;
   localparam int SP    = 3;
   localparam int FTW   = 32;
   localparam int TS    = 5;
   localparam int MSG_CYC = DEPTH * SP;

   logic clk = 1'b0;
   logic reset = 1'b1;

   wspr_symbol_sequencer_if #(.SYMBOL_BITS(SB), .DEPTH(DEPTH), .FTW_WIDTH(FTW)) bus ();

   wspr_symbol_sequencer #(
      .SYMBOL_BITS(SB), .DEPTH(DEPTH), .SYMBOL_PERIOD(SP),
      .FTW_WIDTH(FTW), .TONE_STEP(TS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: stored message, playing flag, cycles since start.
   logic [SB-1:0] msg[$];
   bit playing = 1'b0;
   int play_t  = 0;
   bit done_e  = 1'b0;
   bit rp_lvl  = 1'b0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int idx_e;
      int sym_e;
      idx_e = playing ? (play_t / SP) % DEPTH : 0;
      sym_e = playing ? int'(msg[idx_e]) : 0;
      chk("wr_ready", bus.wr_ready, !playing && msg.size() < DEPTH);
      chk("loaded", bus.loaded, msg.size() == DEPTH);
      chk("busy", bus.busy, playing);
      chk("symbol_valid", bus.symbol_valid, playing);
      chk("symbol_strobe", bus.symbol_strobe, playing && (play_t % SP == 0));
      chk("index", bus.index, idx_e);
      chk("symbol", bus.symbol, sym_e);
      chk("tone_offset", bus.tone_offset, sym_e * TS);
      chk("done", bus.done, done_e);
   endtask

   task automatic model_reset();
      msg.delete();
      playing = 1'b0;
      play_t  = 0;
      done_e  = 1'b0;
   endtask

   task automatic step(input bit wv, input logic [SB-1:0] wd, input bit fl,
                       input bit st, input bit ab);
      @(negedge clk);
      check_outputs();
      bus.wr_valid  = wv;
      bus.wr_data   = wd;
      bus.flush     = fl;
      bus.start     = st;
      bus.abort     = ab;
      bus.repeat_en = rp_lvl;
      done_e = 1'b0;
      if (playing) begin
         if (ab) playing = 1'b0;
         else if ((play_t + 1) % MSG_CYC == 0 && !rp_lvl) begin
            playing = 1'b0;
            done_e  = 1'b1;
         end else play_t++;
      end else if (msg.size() < DEPTH) begin
         if (fl) msg.delete();
         else if (wv) msg.push_back(wd);
      end else begin
         if (fl) msg.delete();
         else if (st && !ab) begin
            playing = 1'b1;
            play_t  = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic go();
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   // Reset lands mid-cycle, so outputs must clear without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      check_outputs();
      bus.wr_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1 check_outputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load_msg(input logic [SB-1:0] a, input logic [SB-1:0] b,
                           input logic [SB-1:0] c, input logic [SB-1:0] d);
      step(1'b1, a, 1'b0, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0, 1'b0);
      step(1'b1, c, 1'b0, 1'b0, 1'b0);
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.flush     = 1'b0;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.repeat_en = 1'b0;
      #1 check_outputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Load 3,1,0,2 with a trailing 5th write that must be refused.
      load_msg(2'd3, 2'd1, 2'd0, 2'd2);
      step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      idle(1);

      // Plain playback, then start again right on the done cycle.
      go();
      idle(12);
      go();
      idle(14);

      // Repeat for more than one pass, then drop it mid-message.
      rp_lvl = 1'b1;
      go();
      idle(20);
      rp_lvl = 1'b0;
      idle(15);

      // Abort in the 2nd symbol, replay, then start+abort together.
      go();
      idle(4);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      idle(2);
      go();
      idle(14);
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      idle(2);

      // Flush during play is ignored; flush in READY empties.
      go();
      idle(3);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle(12);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle(2);

      // Start with only 2 of 4 loaded is ignored.
      step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      go();
      idle(2);
      step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      load_msg(2'd2, 2'd3, 2'd1, 2'd0);
      idle(1);

      // Reset during the 3rd symbol.
      go();
      idle(7);
      do_reset();
      idle(2);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         bit wv, fl, st, ab;
         logic [SB-1:0] wd;
         wv = ($urandom_range(0, 99) < 60);
         wd = SB'($urandom_range(0, (1 << SB) - 1));
         fl = ($urandom_range(0, 99) < 2);
         st = ($urandom_range(0, 99) < 25);
         ab = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 4) rp_lvl = !rp_lvl;
         if (i % 997 == 500) do_reset();
         else step(wv, wd, fl, st, ab);
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/wspr_symbol_sequencer.md
# wspr_symbol_sequencer

Parametrised M-FSK symbol sequencer for the WSPR transmitter chain. It buffers a complete encoded message of DEPTH symbols delivered from the UART/encoder path, then plays it back on command. Each symbol is held for exactly SYMBOL_PERIOD clock cycles, with optional continuous repeat and abort. It drives the symbol index and tone offset consumed by the NCO/delta-sigma modulator stage. Compared with the fixed 162×2-bit WSPR path, symbol width, message depth, symbol timing and tone spacing are all parameters.

## Interface
Parameters:
- SYMBOL_BITS, 2: bits per symbol (2^SYMBOL_BITS tones).
- DEPTH, 162: symbols per message; must be ≥ 2.
- SYMBOL_PERIOD, 34133333: clock cycles per symbol (0.6827 s at 50 MHz); must be ≥ 2.
- FTW_WIDTH, 32: width of tone_offset.
- TONE_STEP, 117: tuning-word increment per symbol value.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  symbol write request.
- wr_data  in  SYMBOL_BITS  symbol to append.
- wr_ready  out  1  buffer accepts a write this cycle.
- flush  in  1  empty the buffer (ignored while busy).
- start  in  1  begin playback (single-cycle pulse or level; edge not required).
- abort  in  1  stop playback immediately.
- repeat_en  in  1  loop the message instead of finishing.
- loaded  out  1  buffer holds DEPTH symbols.
- busy  out  1  playback active.
- symbol_valid  out  1  symbol/tone_offset are meaningful.
- symbol_strobe  out  1  one-cycle pulse on the first cycle of every symbol.
- index  out  clog2(DEPTH)  position of current symbol.
- symbol  out  SYMBOL_BITS  current symbol.
- tone_offset  out  FTW_WIDTH  symbol × TONE_STEP, zero-extended/truncated to FTW_WIDTH.
- done  out  1  one-cycle pulse when a non-repeating playback completes.

## Operation
- States: LOAD (count < DEPTH), READY (count = DEPTH, idle), PLAY.
- Reset: state LOAD, write count 0, wr_ready=1; loaded, busy, symbol_valid, symbol_strobe, done = 0; index, symbol, tone_offset = 0. Buffer storage is not reset.
- LOAD: wr_ready=1. A write occurs when wr_valid && wr_ready; data stored at address count, count increments. The DEPTH-th write moves to READY (loaded=1, wr_ready=0).
- READY/PLAY: wr_ready=0; wr_valid ignored.
- flush in LOAD or READY: count←0, state LOAD, loaded=0; flush wins over a same-cycle write. flush in PLAY ignored.
- start in READY with abort=0: enter PLAY. start in LOAD or PLAY: ignored.
- PLAY: index begins at 0; period counter runs SYMBOL_PERIOD cycles per symbol; at the last cycle of a symbol, index increments.
- End of last symbol (index = DEPTH-1, final cycle): if repeat_en=1 (sampled that cycle), index wraps to 0 and playback continues seamlessly. Otherwise: state READY, done=1 for one cycle.
- abort in PLAY: state READY next cycle, busy=0, symbol_valid=0, no done pulse. abort wins over start in the same cycle. The buffer is preserved, so the message can be replayed.
- tone_offset = symbol × TONE_STEP, registered with symbol. When symbol_valid=0, symbol, tone_offset and index read 0.

## Timing
- Write: data accepted on the clk edge where wr_valid && wr_ready. loaded rises the cycle after the DEPTH-th write.
- start sampled at edge t. From t+1: busy=1, symbol_valid=1, symbol_strobe=1, index=0, symbol=mem[0].
- Each symbol is visible for exactly SYMBOL_PERIOD cycles. symbol_strobe is high on the first of those cycles only.
- Non-repeating run: busy high for exactly DEPTH×SYMBOL_PERIOD cycles. On the following cycle, busy=0, symbol_valid=0 and done=1; the next cycle done=0.
- Repeat wrap: index goes DEPTH-1 → 0 with no gap cycle; symbol_strobe pulses on the wrap.
- start is accepted again on the same cycle done is high (state already READY).
- abort sampled at edge t: busy=0 and symbol_valid=0 from t+1.
- Reset asserted mid-playback: all outputs return to reset values asynchronously. The buffer count clears, so the message must be reloaded.

## Test plan
Configuration for all scenarios: DEPTH=4, SYMBOL_PERIOD=3, SYMBOL_BITS=2, TONE_STEP=5.
- Reset then write 3,1,0,2 with wr_valid held high → wr_ready drops after the 4th write; loaded=1; a 5th wr_valid is not accepted.
- start pulse → symbol sequence 3,3,3,1,1,1,0,0,0,2,2,2 and tone_offset 15,15,15,5,5,5,0,0,0,10,10,10 over 12 cycles. symbol_strobe on cycles 1, 4, 7 and 10; done one cycle after the 12th; busy high exactly 12 cycles.
- repeat_en=1 → after the symbol at index 3, index returns to 0 with no gap and done is never asserted; drop repeat_en mid-message → the run finishes at the end of that pass with a done pulse.
- abort during the 2nd symbol → busy=0 next cycle and no done pulse. A following start replays from symbol 3 (buffer intact). Same-cycle start+abort in READY → stays idle.
- start while only 2 symbols are loaded → ignored. flush in READY → loaded=0, wr_ready=1. flush during PLAY → ignored.
- Assert reset during the 3rd symbol → all outputs 0 immediately, wr_ready=1, loaded=0.
